// File: rtl/af_push_sender_pkg.sv
// Shared types and helpers for the almost-full push sender.
package af_sender_pkg;

  // Push-control states: SEND pushes, PAUSE waits for almost_full to clear,
  // RESUME serves the hysteresis gap before pushing again.
  typedef enum logic [1:0] {
    SEND   = 2'd0,
    PAUSE  = 2'd1,
    RESUME = 2'd2
  } af_state_e;

  // Width of the beat and stall counters.
  localparam int CNT_W = 32;

  // Bits needed to index 'depth' entries (at least 1).
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/af_push_sender_hold_buf.sv
// Circular hold queue: HOLD_DEPTH entries of DATA_WIDTH bits, head visible
// combinationally on rd_data. HOLD_DEPTH must be a power of two so the
// pointers wrap by natural overflow.
module af_hold_buf
  import af_sender_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int HOLD_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic [DATA_WIDTH-1:0]       wr_data,
  input  logic                        pop,
  output logic [DATA_WIDTH-1:0]       rd_data,
  output logic [ptr_w(HOLD_DEPTH):0]  count,
  output logic                        full,
  output logic                        empty
);

  localparam int PTR_W = ptr_w(HOLD_DEPTH);

  logic [DATA_WIDTH-1:0] mem [HOLD_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;

  // Write the accepted beat at the tail.
  // NOTE: the storage array is deliberately not reset; the pointers and count
  // define which entries are valid, so resetting wide data only costs logic.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Advance pointers and track occupancy; simultaneous push and pop cancel.
  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of its neighbours, matching real flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == (PTR_W + 1)'(HOLD_DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/af_push_sender.sv
// Upstream producer for a FIFO in almost-full backpressure mode: buffers a
// valid/ready stream and pushes beats downstream with valid only, pausing on
// a pipelined copy of almost_full and resuming after a hysteresis gap.
module af_push_sender
  import af_sender_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int HOLD_DEPTH = 4,
  parameter int AF_PIPE    = 2,
  parameter int RESUME_GAP = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  almost_full,
  input  logic                  m_overflow,
  output logic [CNT_W-1:0]      beat_count,
  output logic [CNT_W-1:0]      stall_count,
  output logic                  error
);

  localparam int GAP_W = ptr_w(RESUME_GAP + 1);

  af_state_e             state;
  af_state_e             state_next;
  logic [GAP_W-1:0]      gap_cnt;
  logic [GAP_W-1:0]      gap_next;
  logic                  af_d;
  logic                  accept;
  logic                  pop;
  logic                  stall;
  logic                  buf_full;
  logic                  buf_empty;
  logic [DATA_WIDTH-1:0] head;
  logic [ptr_w(HOLD_DEPTH):0] buf_count;

  // almost_full as seen by the control logic, AF_PIPE cycles late.
  if (AF_PIPE == 0) begin : g_af_wire
    assign af_d = almost_full;
  end else begin : g_af_pipe
    logic [AF_PIPE-1:0] af_sr;

    // Shift almost_full down the pipe; reset to 1 so nothing is pushed until
    // the FIFO's real status has propagated through.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        af_sr <= '1;
      end else begin
        af_sr[0] <= almost_full;
        for (int i = 1; i < AF_PIPE; i++) begin
          af_sr[i] <= af_sr[i-1];
        end
      end
    end

    assign af_d = af_sr[AF_PIPE-1];
  end

  // s_ready comes from registered occupancy only, never from this cycle's pop.
  assign s_ready = rst_n & ~buf_full;
  assign accept  = s_valid & s_ready;
  assign pop     = (state == SEND) & ~af_d & ~buf_empty;
  assign stall   = ~buf_empty & ~pop;

  af_hold_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .HOLD_DEPTH (HOLD_DEPTH)
  ) u_hold_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (accept),
    .wr_data (s_data),
    .pop     (pop),
    .rd_data (head),
    .count   (buf_count),
    .full    (buf_full),
    .empty   (buf_empty)
  );

  // Next-state decode for the pause/resume hysteresis.
  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    gap_next   = gap_cnt;
    unique case (state)
      SEND: begin
        if (af_d) state_next = PAUSE;
      end
      PAUSE: begin
        if (!af_d) begin
          if (RESUME_GAP == 0) begin
            state_next = SEND;
          end else begin
            state_next = RESUME;
            gap_next   = GAP_W'(RESUME_GAP);
          end
        end
      end
      RESUME: begin
        if (af_d) begin
          state_next = PAUSE;
        end else if (gap_cnt == '0) begin
          state_next = SEND;
        end else begin
          gap_next = gap_cnt - 1'b1;
        end
      end
      default: state_next = PAUSE;
    endcase
  end

  // State and gap-counter registers; reset parks the sender in PAUSE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= PAUSE;
      gap_cnt <= '0;
    end else begin
      state   <= state_next;
      gap_cnt <= gap_next;
    end
  end

  // Registered push strobe, data and statistics; beat_count is stepped
  // together with m_valid so it always includes the beat on m_data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid     <= 1'b0;
      m_data      <= '0;
      beat_count  <= '0;
      stall_count <= '0;
      error       <= 1'b0;
    end else begin
      m_valid <= pop;
      if (pop) begin
        m_data     <= head;
        beat_count <= beat_count + 1'b1;
      end
      if (stall) begin
        stall_count <= stall_count + 1'b1;
      end
      error <= error | m_overflow;
    end
  end

  logic unused_count;
  assign unused_count = ^buf_count;

endmodule

// File: tb/tb_af_push_sender.sv
// Self-checking bench for af_push_sender: directed phases plus randomized
// traffic, compared every cycle against a behavioural model built from a
// queue, a delay line for almost_full and a run-length rule for resuming.
module tb_af_push_sender;
  import af_sender_pkg::*;

  localparam int DW   = 512;
  localparam int HD   = 4;
  localparam int AFP  = 2;
  localparam int RG   = 2;
  // Consecutive low cycles of delayed almost_full needed before a push:
  // one to leave PAUSE, then RG+1 cycles in RESUME.
  localparam int NEED = (RG == 0) ? 1 : RG + 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          almost_full;
  logic          m_overflow;
  logic [31:0]   beat_count;
  logic [31:0]   stall_count;
  logic          error;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [DW-1:0] mq[$];
  logic          af_hist[$];
  int            low_run;
  logic          e_mvalid;
  logic [DW-1:0] e_mdata;
  logic [31:0]   e_beat;
  logic [31:0]   e_stall;
  logic          e_err;

  af_push_sender #(
    .DATA_WIDTH (DW),
    .HOLD_DEPTH (HD),
    .AF_PIPE    (AFP),
    .RESUME_GAP (RG)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .almost_full (almost_full),
    .m_overflow  (m_overflow),
    .beat_count  (beat_count),
    .stall_count (stall_count),
    .error       (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_beat();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // One clock: drive inputs, check s_ready, advance the model, then check the
  // registered outputs half a cycle after the edge.
  task automatic step(input logic rn, input logic sv, input logic [DW-1:0] sd,
                      input logic af, input logic ovf);
    logic e_ready;
    logic afd;
    logic pop;
    rst_n       = rn;
    s_valid     = sv;
    s_data      = sd;
    almost_full = af;
    m_overflow  = ovf;
    #1;
    e_ready = rn && (mq.size() != HD);
    chk("s_ready", DW'(s_ready), DW'(e_ready));

    if (!rn) begin
      mq.delete();
      af_hist.delete();
      for (int i = 0; i < AFP; i++) af_hist.push_back(1'b1);
      low_run  = 0;
      e_mvalid = 1'b0;
      e_mdata  = '0;
      e_beat   = '0;
      e_stall  = '0;
      e_err    = 1'b0;
    end else begin
      afd = (AFP == 0) ? af : af_hist[0];
      pop = (low_run >= NEED) && !afd && (mq.size() != 0);
      e_mvalid = pop;
      if (pop) begin
        e_mdata = mq[0];
        e_beat  = e_beat + 1;
      end
      if ((mq.size() != 0) && !pop) e_stall = e_stall + 1;
      e_err = e_err | ovf;
      if (pop) void'(mq.pop_front());
      if (sv && e_ready) mq.push_back(sd);
      low_run = afd ? 0 : ((low_run < 1000) ? low_run + 1 : low_run);
      if (AFP != 0) begin
        void'(af_hist.pop_front());
        af_hist.push_back(af);
      end
    end

    @(posedge clk);
    @(negedge clk);
    chk("m_valid",     DW'(m_valid),     DW'(e_mvalid));
    chk("m_data",      m_data,           e_mdata);
    chk("beat_count",  DW'(beat_count),  DW'(e_beat));
    chk("stall_count", DW'(stall_count), DW'(e_stall));
    chk("error",       DW'(error),       DW'(e_err));
  endtask

  initial begin
    int first_idx;
    logic af_r;
    rst_n       = 1'b0;
    s_valid     = 1'b0;
    s_data      = '0;
    almost_full = 1'b0;
    m_overflow  = 1'b0;
    @(negedge clk);

    // Reset values.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, rand_beat(), 1'b0, 1'b0);

    // Reset exit: first push six cycles after release with AF_PIPE=2, gap 2.
    first_idx = -1;
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b1, DW'(100 + k), 1'b0, 1'b0);
      if (m_valid === 1'b1 && first_idx < 0) first_idx = k;
    end
    chk("first_push", DW'(first_idx), DW'(6));

    // Streaming 0..15 back to back.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, DW'(i), 1'b0, 1'b0);

    // Stop: almost_full high, upstream keeps offering; queue fills.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, rand_beat(), 1'b1, 1'b0);
    chk("stop_ready", DW'(s_ready), DW'(0));
    chk("stop_valid", DW'(m_valid), DW'(0));

    // Resume and drain the held beats.
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, rand_beat(), 1'b0, 1'b0);

    // Glitch during RESUME: one-cycle almost_full pulse restarts the gap.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, rand_beat(), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, rand_beat(), 1'b0, 1'b0);
    step(1'b1, 1'b1, rand_beat(), 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, rand_beat(), 1'b0, 1'b0);

    // Overflow pulse: sticky error, pushing unaffected, cleared by reset.
    step(1'b1, 1'b1, rand_beat(), 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, rand_beat(), 1'b0, 1'b0);
    chk("err_sticky", DW'(error), DW'(1));
    step(1'b0, 1'b1, rand_beat(), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, rand_beat(), 1'b0, 1'b0);

    // Randomized traffic with bursty almost_full and a mid-run reset.
    af_r = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(5) == 0) af_r = ~af_r;
      step((i == 200 || i == 201) ? 1'b0 : 1'b1,
           ($urandom_range(3) != 0), rand_beat(), af_r,
           ($urandom_range(49) == 0));
    end

    // Drain.
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, rand_beat(), 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
